sipo_deser: RTL and testbench

Parametrised serial-to-parallel deserialiser: shifts in one bit per enabled cycle, tracks bit position, and emits each completed WIDTH-bit word through a valid/ready output register. It extends the 8-bit shift-register/3-bit-counter block with configurable width, configurable bit order, frame resynchronisation and output-overflow detection. It sits between a serial front end (bit stream plus enable strobe) and word-oriented datapath logic.

---
 rtl/sipo_pkg.sv | 28 ++
 rtl/sipo_deser_bit_counter.sv | 39 +++
 rtl/sipo_deser.sv | 97 +++++++++
 tb/tb_sipo_deser.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// sipo_pkg: shared definitions for the serial/parallel conversion blocks.
//   LSB_FIRST / MSB_FIRST : bit-order selector values.
//   next_shift()          : one-bit shift step on a 64-bit container. Callers
//                           zero-extend their register into it and truncate
//                           the result back to their own width.
package sipo_pkg;

  localparam int LSB_FIRST = 0;
  localparam int MSB_FIRST = 1;

  // For LSB-first order the new bit enters at the top of the live word
  // (bit width-1), so after `width` shifts the first bit has reached bit 0.
  // Bits above width-1 stay zero provided the caller's input has them zero.
  function automatic logic [63:0] next_shift(input logic [63:0] shift,
                                             input logic        b,
                                             input logic        msb_first,
                                             input int          width);
    logic [63:0] r;
    if (msb_first) begin
      r = {shift[62:0], b};
    end else begin
      r = shift >> 1;
      r[width-1] = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/sipo_deser_bit_counter.sv
// bit_counter_mod: CW-bit modulo-MOD up-counter.
//   clk, rst : clock, async active-low reset
//   inc      : advance by one, wrapping from MOD-1 to 0
//   load1    : synchronous load of 1 (highest priority)
//   clr      : synchronous clear to 0
//   cnt      : current count
//   tc       : terminal count, cnt == MOD-1
module bit_counter_mod #(
  parameter int MOD = 8,
  parameter int CW  = $clog2(MOD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          load1,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  localparam logic [CW-1:0] CNT_LAST = CW'(MOD - 1);

  assign tc = (cnt == CNT_LAST);

  // The explicit terminal compare handles the wrap when MOD is not a power
  // of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= CW'(1);
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= tc ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// sipo_deser: serial-to-parallel deserialiser with valid/ready output register.
//   clk, rst  : clock, async active-low reset
//   en, si    : bit strobe and serial data (si sampled when en=1)
//   sof       : start-of-frame, realigns the bit counter
//   shift_q   : live shift register
//   bit_cnt   : bits held in the current partial word
//   last      : this cycle's sampled bit completes a word
//   out_data  : captured word; out_valid / out_ready handshake
//   ovf       : sticky overflow (word completed while output still full)
//   ovf_clr   : synchronous clear of ovf; a coincident set wins
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0,
  parameter int CW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             si,
  input  logic             sof,
  output logic [WIDTH-1:0] shift_q,
  output logic [CW-1:0]    bit_cnt,
  output logic             last,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf,
  input  logic             ovf_clr
);

  logic [63:0]      shift_ext;
  logic [WIDTH-1:0] shift_nx;
  logic             tc;
  logic             ovf_set;
  logic             capture;

  always_comb begin
    shift_ext = '0;
    shift_ext[WIDTH-1:0] = shift_q;
  end

  assign shift_nx = WIDTH'(next_shift(shift_ext, si, MSB_FIRST != 0, WIDTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
    end else if (en) begin
      shift_q <= shift_nx;
    end
  end

  // A sof with a bit makes that bit the first of a new word (count 1);
  // a sof without a bit just empties the partial word.
  bit_counter_mod #(
    .MOD (WIDTH),
    .CW  (CW)
  ) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (en & ~sof),
    .load1 (en & sof),
    .clr   (~en & sof),
    .cnt   (bit_cnt),
    .tc    (tc)
  );

  assign last = en & tc & ~sof;

  // A completed word is only dropped when the register is full and not
  // being drained at this edge; a simultaneous drain makes room for it.
  assign ovf_set = last & out_valid & ~out_ready;
  assign capture = last & ~ovf_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (capture) begin
        out_data  <= shift_nx;
        out_valid <= 1'b1;
      end else if (out_valid & out_ready) begin
        out_valid <= 1'b0;
      end

      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: three instances (W=8 LSB-first, W=8 MSB-first, W=5 LSB-first)
// share one stimulus stream. A bit-list reference model pushes expected words
// into per-instance queues; a negedge monitor pops and compares them.
module tb_sipo_deser;

  logic clk, rst, en, si, sof, out_ready, ovf_clr;

  logic [7:0] d0_shift, d0_data;
  logic [2:0] d0_cnt;
  logic       d0_last, d0_valid, d0_ovf;
  logic [7:0] d1_shift, d1_data;
  logic [2:0] d1_cnt;
  logic       d1_last, d1_valid, d1_ovf;
  logic [4:0] d2_shift, d2_data;
  logic [2:0] d2_cnt;
  logic       d2_last, d2_valid, d2_ovf;

  sipo_deser #(.WIDTH(8), .MSB_FIRST(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .si(si), .sof(sof),
    .shift_q(d0_shift), .bit_cnt(d0_cnt), .last(d0_last),
    .out_data(d0_data), .out_valid(d0_valid), .out_ready(out_ready),
    .ovf(d0_ovf), .ovf_clr(ovf_clr));

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .si(si), .sof(sof),
    .shift_q(d1_shift), .bit_cnt(d1_cnt), .last(d1_last),
    .out_data(d1_data), .out_valid(d1_valid), .out_ready(out_ready),
    .ovf(d1_ovf), .ovf_clr(ovf_clr));

  sipo_deser #(.WIDTH(5), .MSB_FIRST(0)) dut2 (
    .clk(clk), .rst(rst), .en(en), .si(si), .sof(sof),
    .shift_q(d2_shift), .bit_cnt(d2_cnt), .last(d2_last),
    .out_data(d2_data), .out_valid(d2_valid), .out_ready(out_ready),
    .ovf(d2_ovf), .ovf_clr(ovf_clr));

  logic [63:0] a_data[3], a_shift[3];
  logic [2:0]  a_cnt[3];
  logic        a_last[3], a_valid[3], a_ovf[3];

  assign a_data[0]  = {56'b0, d0_data};
  assign a_data[1]  = {56'b0, d1_data};
  assign a_data[2]  = {59'b0, d2_data};
  assign a_shift[0] = {56'b0, d0_shift};
  assign a_shift[1] = {56'b0, d1_shift};
  assign a_shift[2] = {59'b0, d2_shift};
  assign a_cnt[0] = d0_cnt;   assign a_cnt[1] = d1_cnt;   assign a_cnt[2] = d2_cnt;
  assign a_last[0] = d0_last; assign a_last[1] = d1_last; assign a_last[2] = d2_last;
  assign a_valid[0] = d0_valid; assign a_valid[1] = d1_valid; assign a_valid[2] = d2_valid;
  assign a_ovf[0] = d0_ovf;   assign a_ovf[1] = d1_ovf;   assign a_ovf[2] = d2_ovf;

  localparam int WD [3] = '{8, 8, 5};
  localparam int MS [3] = '{0, 1, 0};

  // Reference model: list of bits received in the current word, output
  // occupancy, sticky overflow, and queue of words awaiting consumption.
  int          cnt_m [3];
  bit          bits_m [3][64];
  bit          occ_m [3];
  bit          ovf_m [3];
  logic [63:0] exp_q [3][$];
  int          pop_cnt [3];

  int checks = 0;
  int failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_word(input int d);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < WD[d]; i++)
      if (bits_m[d][i]) w[(MS[d] != 0) ? (WD[d] - 1 - i) : i] = 1'b1;
    return w;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      cnt_m[d] = 0;
      occ_m[d] = 1'b0;
      ovf_m[d] = 1'b0;
      exp_q[d].delete();
    end
  endtask

  // Applies the behaviour rules to one clock edge with the current inputs.
  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      bit done;
      done = 1'b0;
      if (en && sof) begin
        bits_m[d][0] = si;
        cnt_m[d] = 1;
      end else if (en) begin
        bits_m[d][cnt_m[d]] = si;
        if (cnt_m[d] == WD[d] - 1) begin
          done = 1'b1;
          cnt_m[d] = 0;
        end else begin
          cnt_m[d]++;
        end
      end else if (sof) begin
        cnt_m[d] = 0;
      end

      if (done && occ_m[d] && !out_ready) begin
        ovf_m[d] = 1'b1;
      end else begin
        if (ovf_clr) ovf_m[d] = 1'b0;
        if (done) begin
          exp_q[d].push_back(model_word(d));
          occ_m[d] = 1'b1;
        end else if (occ_m[d] && out_ready) begin
          occ_m[d] = 1'b0;
        end
      end
    end
  endtask

  task automatic step(input logic e, input logic s, input logic f);
    en = e; si = s; sof = f;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) step(1'b1, w[i], 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_d%0d_shift", tag, d), a_shift[d], 64'd0);
      chk($sformatf("%s_d%0d_cnt", tag, d), {61'd0, a_cnt[d]}, 64'd0);
      chk($sformatf("%s_d%0d_data", tag, d), a_data[d], 64'd0);
      chk($sformatf("%s_d%0d_valid", tag, d), {63'd0, a_valid[d]}, 64'd0);
      chk($sformatf("%s_d%0d_ovf", tag, d), {63'd0, a_ovf[d]}, 64'd0);
    end
  endtask

  // Monitor: compares state against the model and pops words as consumed.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int d = 0; d < 3; d++) begin
          bit exp_last;
          exp_last = en && !sof && (cnt_m[d] == WD[d] - 1);
          chk($sformatf("mon_d%0d_cnt", d), {61'd0, a_cnt[d]}, 64'(cnt_m[d]));
          chk($sformatf("mon_d%0d_valid", d), {63'd0, a_valid[d]}, {63'd0, occ_m[d]});
          chk($sformatf("mon_d%0d_ovf", d), {63'd0, a_ovf[d]}, {63'd0, ovf_m[d]});
          chk($sformatf("mon_d%0d_last", d), {63'd0, a_last[d]}, {63'd0, exp_last});
          if (a_valid[d] === 1'b1) begin
            if (exp_q[d].size() == 0) begin
              checks++;
              failures++;
              $display("FAIL mon_d%0d_unexpected_word actual=0x%0h expected=none", d, a_data[d]);
            end else begin
              chk($sformatf("mon_d%0d_data", d), a_data[d], exp_q[d][0]);
              if (out_ready) begin
                void'(exp_q[d].pop_front());
                pop_cnt[d]++;
              end
            end
          end
        end
      end
    end
  end

  initial begin
    int p0;
    logic [7:0] seq1;
    logic [6:0] tail5;

    rst = 1'b0; en = 1'b0; si = 1'b0; sof = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    for (int d = 0; d < 3; d++) pop_cnt[d] = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("rst0");
    rst = 1'b1;

    // 1/2: stream 1,0,1,1,0,0,1,0 -> 0x4D LSB-first, 0xB2 MSB-first
    seq1 = 8'b0100_1101;
    for (int i = 0; i < 7; i++) step(1'b1, seq1[i], 1'b0);
    en = 1'b1; si = seq1[7]; sof = 1'b0;
    #1;
    chk("t1_last_d0", {63'd0, d0_last}, 64'd1);
    chk("t1_last_d1", {63'd0, d1_last}, 64'd1);
    step(1'b1, seq1[7], 1'b0);
    chk("t1_valid_d0", {63'd0, d0_valid}, 64'd1);
    chk("t1_data_d0", {56'd0, d0_data}, 64'h4D);
    chk("t1_data_d1", {56'd0, d1_data}, 64'hB2);
    chk("t1_cnt_d0", {61'd0, d0_cnt}, 64'd0);

    // 3: 15 ones into WIDTH=5 -> three 0x1F words
    step(1'b0, 1'b0, 1'b1);
    p0 = pop_cnt[2];
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (i % 5 == 4) begin
        chk("t3_data_d2", {59'd0, d2_data}, 64'h1F);
        chk("t3_cnt_d2", {61'd0, d2_cnt}, 64'd0);
      end
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("t3_words_d2", 64'(pop_cnt[2] - p0), 64'd3);
    chk("t3_ovf_d2", {63'd0, d2_ovf}, 64'd0);

    // 4: overflow with out_ready low
    step(1'b0, 1'b0, 1'b1);
    out_ready = 1'b0;
    send_word(8'hA5);
    chk("t4_first_d0", {56'd0, d0_data}, 64'hA5);
    chk("t4_noovf_d0", {63'd0, d0_ovf}, 64'd0);
    send_word(8'h3C);
    chk("t4_hold_d0", {56'd0, d0_data}, 64'hA5);
    chk("t4_ovf_d0", {63'd0, d0_ovf}, 64'd1);
    ovf_clr = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    ovf_clr = 1'b0;
    chk("t4_ovfclr_d0", {63'd0, d0_ovf}, 64'd0);
    chk("t4_still_valid_d0", {63'd0, d0_valid}, 64'd1);
    out_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk("t4_drained_d0", {63'd0, d0_valid}, 64'd0);

    // 5: sof realigns mid-word; the sof bit becomes bit 0
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("t5_cnt_d0", {61'd0, d0_cnt}, 64'd1);
    chk("t5_novalid_d0", {63'd0, d0_valid}, 64'd0);
    tail5 = 7'b100_0010;
    for (int i = 0; i < 7; i++) step(1'b1, tail5[i], 1'b0);
    chk("t5_valid_d0", {63'd0, d0_valid}, 64'd1);
    chk("t5_data_d0", {56'd0, d0_data}, 64'h85);

    // 6: async reset mid-word with a pending output word
    step(1'b0, 1'b0, 1'b1);
    out_ready = 1'b0;
    send_word(8'h5A);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    chk("t6_pre_cnt_d0", {61'd0, d0_cnt}, 64'd5);
    chk("t6_pre_valid_d0", {63'd0, d0_valid}, 64'd1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk_all_zero("t6_rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    send_word(8'h3C);
    chk("t6_valid_d0", {63'd0, d0_valid}, 64'd1);
    chk("t6_data_d0", {56'd0, d0_data}, 64'h3C);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0);
    end
    ovf_clr = 1'b0;
    out_ready = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0);
    for (int d = 0; d < 3; d++)
      chk($sformatf("end_d%0d_queue_empty", d), 64'(exp_q[d].size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
